cal_ctrl: RTL and testbench

- Calendar controller that owns the day/month/year registers and sequences their updates.
- Advances the date on each day tick from the 24-hour counter.
- Provides a button-driven set mode (select field, increment/decrement) with correct month-length and leap-year handling.
- Sits between the time-of-day counter and the display/BCD path; replaces the ripple-clocked day/month chain with one synchronous block.

---
 rtl/cal_pkg.sv | 30 +++
 rtl/cal_dim.sv | 19 +
 rtl/cal_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cal_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// Shared types and constants for the calendar controller: FSM states,
// edit-field codes, month bounds, month lengths and the leap-year rule.
package cal_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SET_DAY   = 2'd1,
    ST_SET_MONTH = 2'd2,
    ST_SET_YEAR  = 2'd3
  } state_e;

  localparam logic [1:0] FIELD_NONE  = 2'd0;
  localparam logic [1:0] FIELD_DAY   = 2'd1;
  localparam logic [1:0] FIELD_MONTH = 2'd2;
  localparam logic [1:0] FIELD_YEAR  = 2'd3;

  localparam logic [3:0] MONTH_MIN = 4'd1;
  localparam logic [3:0] MONTH_MAX = 4'd12;

  localparam logic [5:0] DIM_28 = 6'd28;
  localparam logic [5:0] DIM_29 = 6'd29;
  localparam logic [5:0] DIM_30 = 6'd30;
  localparam logic [5:0] DIM_31 = 6'd31;

  function automatic logic is_leap(input logic [15:0] y);
    return ((y % 16'd400) == 16'd0) ||
           (((y % 16'd4) == 16'd0) && ((y % 16'd100) != 16'd0));
  endfunction

endpackage

// File: rtl/cal_dim.sv
// Days-in-month lookup: month/year in, month length (6-bit) out.
module cal_dim
  import cal_pkg::*;
(
  input  logic [3:0]  month,
  input  logic [15:0] year,
  output logic [5:0]  dim
);

  always_comb begin
    dim = DIM_31;
    case (month)
      4'd2:                    dim = is_leap(year) ? DIM_29 : DIM_28;
      4'd4, 4'd6, 4'd9, 4'd11: dim = DIM_30;
      default:                 dim = DIM_31;
    endcase
  end

endmodule

// File: rtl/cal_ctrl.sv
// Calendar controller: day/month/year registers, day-tick advance and
// button-driven set mode. Define CAL_TICK_HOLD_EN to hold one tick during edits.
module cal_ctrl
  import cal_pkg::*;
#(
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2199
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        day_tick,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [4:0]  day,
  output logic [3:0]  month,
  output logic [15:0] year,
  output logic        editing,
  output logic [1:0]  edit_field,
  output logic        date_roll
);

  localparam logic [15:0] Y_MIN = 16'(YEAR_MIN);
  localparam logic [15:0] Y_MAX = 16'(YEAR_MAX);

  state_e      state_q, state_d;
  logic [4:0]  day_q, day_d;
  logic [3:0]  month_q, month_d;
  logic [15:0] year_q, year_d;
  logic        date_roll_q, date_roll_d;
  logic        editing_q, editing_d;
  logic [1:0]  edit_field_q, edit_field_d;

  logic [5:0]  dim_cur, dim_cand;
  logic [3:0]  cand_month, month_up, month_dn;
  logic [15:0] cand_year, year_up, year_dn;
  logic        step_up, step_dn, tick_now, leave_set;

  cal_dim u_dim_cur  (.month(month_q),    .year(year_q),    .dim(dim_cur));
  cal_dim u_dim_cand (.month(cand_month), .year(cand_year), .dim(dim_cand));

  // Mode wins over up/down; up and down together cancel.
  always_comb begin
    step_up   = btn_up & ~btn_down & ~btn_mode;
    step_dn   = btn_down & ~btn_up & ~btn_mode;
    leave_set = (state_q == ST_SET_YEAR) && btn_mode;
    month_up  = (month_q >= MONTH_MAX) ? MONTH_MIN : month_q + 4'd1;
    month_dn  = (month_q <= MONTH_MIN) ? MONTH_MAX : month_q - 4'd1;
    year_up   = (year_q >= Y_MAX) ? Y_MIN : year_q + 16'd1;
    year_dn   = (year_q <= Y_MIN) ? Y_MAX : year_q - 16'd1;
    cand_month = month_q;
    cand_year  = year_q;
    if (state_q == ST_SET_MONTH) cand_month = step_up ? month_up : month_dn;
    if (state_q == ST_SET_YEAR)  cand_year  = step_up ? year_up  : year_dn;
  end

`ifdef CAL_TICK_HOLD_EN
  logic pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (leave_set)                              pending_d = 1'b0;
    else if (state_q != ST_RUN && day_tick)     pending_d = 1'b1;
    tick_now = ((state_q == ST_RUN) && day_tick) ||
               (leave_set && (pending_q || day_tick));
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= 1'b0;
    else     pending_q <= pending_d;
  end
`else
  always_comb begin
    tick_now = (state_q == ST_RUN) && day_tick;
  end
`endif

  always_comb begin
    state_d = state_q;
    if (btn_mode) begin
      case (state_q)
        ST_RUN:       state_d = ST_SET_DAY;
        ST_SET_DAY:   state_d = ST_SET_MONTH;
        ST_SET_MONTH: state_d = ST_SET_YEAR;
        ST_SET_YEAR:  state_d = ST_RUN;
        default:      state_d = ST_RUN;
      endcase
    end
    editing_d = (state_d != ST_RUN);
    case (state_d)
      ST_SET_DAY:   edit_field_d = FIELD_DAY;
      ST_SET_MONTH: edit_field_d = FIELD_MONTH;
      ST_SET_YEAR:  edit_field_d = FIELD_YEAR;
      default:      edit_field_d = FIELD_NONE;
    endcase
  end

  // A tick and a field step never coincide: in SET states a tick only
  // applies with btn_mode, which suppresses stepping.
  always_comb begin
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    date_roll_d = 1'b0;
    if (tick_now) begin
      if ({1'b0, day_q} < dim_cur) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d       = 5'd1;
        date_roll_d = 1'b1;
        if (month_q < MONTH_MAX) begin
          month_d = month_q + 4'd1;
        end else begin
          month_d = MONTH_MIN;
          year_d  = year_up;
        end
      end
    end else if (step_up || step_dn) begin
      case (state_q)
        ST_SET_DAY: begin
          if (step_up) day_d = ({1'b0, day_q} >= dim_cur) ? 5'd1 : day_q + 5'd1;
          else         day_d = (day_q <= 5'd1) ? dim_cur[4:0] : day_q - 5'd1;
        end
        ST_SET_MONTH: begin
          month_d = cand_month;
          day_d   = ({1'b0, day_q} > dim_cand) ? dim_cand[4:0] : day_q;
        end
        ST_SET_YEAR: begin
          year_d = cand_year;
          day_d  = ({1'b0, day_q} > dim_cand) ? dim_cand[4:0] : day_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      day_q        <= 5'd1;
      month_q      <= MONTH_MIN;
      year_q       <= Y_MIN;
      date_roll_q  <= 1'b0;
      editing_q    <= 1'b0;
      edit_field_q <= FIELD_NONE;
    end else begin
      state_q      <= state_d;
      day_q        <= day_d;
      month_q      <= month_d;
      year_q       <= year_d;
      date_roll_q  <= date_roll_d;
      editing_q    <= editing_d;
      edit_field_q <= edit_field_d;
    end
  end

  assign day        = day_q;
  assign month      = month_q;
  assign year       = year_q;
  assign editing    = editing_q;
  assign edit_field = edit_field_q;
  assign date_roll  = date_roll_q;

endmodule

// File: tb/tb_cal_ctrl.sv
// Self-checking bench for cal_ctrl: directed scenarios plus a random run
// against a date model built from the calendar rules.
module tb_cal_ctrl;

  localparam int YMIN = 2000;
  localparam int YMAX = 2199;
`ifdef CAL_TICK_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        day_tick = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [15:0] year;
  logic        editing, date_roll;
  logic [1:0]  edit_field;
  logic [28:0] dut_vec;

  int total = 0;
  int bad   = 0;

  int m_day, m_month, m_year, m_mode, m_roll;
  bit m_pend;

  cal_ctrl #(.YEAR_MIN(YMIN), .YEAR_MAX(YMAX)) dut (
    .clk(clk), .rst(rst), .day_tick(day_tick), .btn_mode(btn_mode),
    .btn_up(btn_up), .btn_down(btn_down), .day(day), .month(month),
    .year(year), .editing(editing), .edit_field(edit_field),
    .date_roll(date_roll)
  );

  assign dut_vec = {day, month, year, editing, edit_field, date_roll};

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  function automatic int dim_of(int m, int y);
    bit leap;
    leap = (y % 400 == 0) || ((y % 4 == 0) && (y % 100 != 0));
    if (m == 2) return leap ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic logic [28:0] model_vec();
    return {5'(m_day), 4'(m_month), 16'(m_year), (m_mode != 0), 2'(m_mode), 1'(m_roll)};
  endfunction

  task automatic model_advance();
    if (m_day < dim_of(m_month, m_year)) m_day++;
    else begin
      m_day  = 1;
      m_roll = 1;
      if (m_month < 12) m_month++;
      else begin
        m_month = 1;
        m_year  = (m_year == YMAX) ? YMIN : m_year + 1;
      end
    end
  endtask

  task automatic model_step(bit t, bit mo, bit u, bit dn);
    m_roll = 0;
    if (m_mode == 0) begin
      if (t)  model_advance();
      if (mo) m_mode = 1;
    end else begin
      if (t && HOLD) m_pend = 1;
      if (mo) begin
        m_mode = (m_mode + 1) % 4;
        if (m_mode == 0 && m_pend) begin
          model_advance();
          m_pend = 0;
        end
      end else if (u != dn) begin
        case (m_mode)
          1: if (u) m_day = (m_day >= dim_of(m_month, m_year)) ? 1 : m_day + 1;
             else   m_day = (m_day == 1) ? dim_of(m_month, m_year) : m_day - 1;
          2: m_month = u ? (m_month % 12) + 1 : ((m_month == 1) ? 12 : m_month - 1);
          default: m_year = u ? ((m_year == YMAX) ? YMIN : m_year + 1)
                              : ((m_year == YMIN) ? YMAX : m_year - 1);
        endcase
        if (m_day > dim_of(m_month, m_year)) m_day = dim_of(m_month, m_year);
      end
    end
  endtask

  task automatic cyc(bit t, bit mo, bit u, bit dn);
    day_tick = t; btn_mode = mo; btn_up = u; btn_down = dn;
    @(posedge clk);
    model_step(t, mo, u, dn);
    #1;
    day_tick = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    m_day = 1; m_month = 1; m_year = YMIN; m_mode = 0; m_roll = 0; m_pend = 0;
    #1;
    rst = 0;
  endtask

  // Drive the buttons to reach d/m/y from RUN, ending back in RUN.
  task automatic set_date(int d, int m, int y);
    cyc(0, 1, 0, 0);
    while (m_day != 1) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    while (m_month != m) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    while (m_year != y) cyc(0, 0, (y > m_year), (y < m_year));
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    while (m_day != d) cyc(0, 0, 1, 0);
    repeat (3) cyc(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dut_vec !== {5'd1, 4'd1, 16'd2000, 1'b0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset: got %h want %h", dut_vec, {5'd1, 4'd1, 16'd2000, 1'b0, 2'd0, 1'b0});
    end
  endtask

  task automatic test_month_roll();
    int rolls = 0;
    for (int i = 0; i < 31; i++) begin
      cyc(1, 0, 0, 0);
      if (date_roll) rolls++;
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL month_roll tick %0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
    total++;
    if ({day, month, year} !== {5'd1, 4'd2, 16'd2000} || rolls != 1) begin
      bad++;
      $display("FAIL month_roll end: got %0d/%0d/%0d rolls=%0d want 1/2/2000 rolls=1",
               day, month, year, rolls);
    end
  endtask

  task automatic test_leap();
    set_date(28, 2, 2023);
    cyc(1, 0, 0, 0);
    total++;
    if ({day, month, year} !== {5'd1, 4'd3, 16'd2023}) begin
      bad++; $display("FAIL leap_2023: got %0d/%0d/%0d want 1/3/2023", day, month, year);
    end
    set_date(28, 2, 2024);
    cyc(1, 0, 0, 0);
    total++;
    if ({day, month, year, date_roll} !== {5'd29, 4'd2, 16'd2024, 1'b0}) begin
      bad++; $display("FAIL leap_2024a: got %0d/%0d/%0d r=%0d want 29/2/2024 r=0", day, month, year, date_roll);
    end
    cyc(1, 0, 0, 0);
    total++;
    if ({day, month, year, date_roll} !== {5'd1, 4'd3, 16'd2024, 1'b1}) begin
      bad++; $display("FAIL leap_2024b: got %0d/%0d/%0d r=%0d want 1/3/2024 r=1", day, month, year, date_roll);
    end
    set_date(28, 2, 2100);
    cyc(1, 0, 0, 0);
    total++;
    if ({day, month, year} !== {5'd1, 4'd3, 16'd2100}) begin
      bad++; $display("FAIL leap_2100: got %0d/%0d/%0d want 1/3/2100", day, month, year);
    end
  endtask

  task automatic test_year_wrap();
    set_date(31, 12, 2199);
    cyc(1, 0, 0, 0);
    total++;
    if ({day, month, year, date_roll} !== {5'd1, 4'd1, 16'd2000, 1'b1}) begin
      bad++; $display("FAIL year_wrap: got %0d/%0d/%0d r=%0d want 1/1/2000 r=1", day, month, year, date_roll);
    end
  endtask

  task automatic test_edit_clamp();
    set_date(31, 1, 2024);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    total++;
    if ({day, month, year, edit_field} !== {5'd29, 4'd2, 16'd2024, 2'd2}) begin
      bad++; $display("FAIL clamp_month: got %0d/%0d/%0d f=%0d want 29/2/2024 f=2", day, month, year, edit_field);
    end
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    total++;
    if ({day, month, year, edit_field} !== {5'd28, 4'd2, 16'd2025, 2'd3}) begin
      bad++; $display("FAIL clamp_year: got %0d/%0d/%0d f=%0d want 28/2/2025 f=3", day, month, year, edit_field);
    end
    cyc(0, 1, 0, 0);
    set_date(1, 2, 2025);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    total++;
    if ({day, editing, edit_field} !== {5'd28, 1'b1, 2'd1}) begin
      bad++; $display("FAIL day_down_wrap: got day=%0d e=%0d f=%0d want day=28 e=1 f=1", day, editing, edit_field);
    end
    repeat (3) cyc(0, 1, 0, 0);
  endtask

  task automatic test_simultaneous();
    logic [28:0] snap;
    logic [3:0]  saved_month;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    snap = dut_vec;
    cyc(0, 0, 1, 1);
    total++;
    if (dut_vec !== snap || dut_vec !== model_vec()) begin
      bad++; $display("FAIL up_down_cancel: got %h want %h", dut_vec, snap);
    end
    saved_month = month;
    cyc(0, 1, 1, 0);
    total++;
    if ({month, edit_field} !== {saved_month, 2'd3}) begin
      bad++; $display("FAIL mode_wins: got m=%0d f=%0d want m=%0d f=3", month, edit_field, saved_month);
    end
    do_reset();
    total++;
    if (dut_vec !== {5'd1, 4'd1, 16'd2000, 1'b0, 2'd0, 1'b0}) begin
      bad++; $display("FAIL reset_mid_edit: got %h want %h", dut_vec, {5'd1, 4'd1, 16'd2000, 1'b0, 2'd0, 1'b0});
    end
  endtask

  task automatic test_tick_hold();
    int exp_day;
    set_date(10, 5, 2030);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    total++;
    if ({day, date_roll} !== {5'd10, 1'b0}) begin
      bad++; $display("FAIL tick_in_set: got day=%0d r=%0d want day=10 r=0", day, date_roll);
    end
    repeat (3) cyc(0, 1, 0, 0);
    exp_day = HOLD ? 11 : 10;
    total++;
    if ({day, month, year, editing} !== {5'(exp_day), 4'd5, 16'd2030, 1'b0}) begin
      bad++; $display("FAIL tick_hold: got %0d/%0d/%0d e=%0d want %0d/5/2030 e=0", day, month, year, editing, exp_day);
    end
  endtask

  task automatic test_random();
    bit t, mo, u, dn;
    for (int i = 0; i < 1500; i++) begin
      t  = ($urandom_range(3) == 0);
      mo = ($urandom_range(7) == 0);
      u  = ($urandom_range(2) == 0);
      dn = ($urandom_range(2) == 0);
      cyc(t, mo, u, dn);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("FAIL random cycle %0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_month_roll();
    test_leap();
    test_year_wrap();
    test_edit_clamp();
    test_simultaneous();
    test_tick_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
